// File: rtl/nios2_ci_timer_gen2.sv
// Avalon-MM interval timer for Nios II CI systems: parametrised counter width,
// programmable prescaler, level IRQ and a one-clock timeout strobe.
module nios2_ci_timer_gen2 #(
   parameter int unsigned COUNT_W        = 32,
   parameter logic [63:0] PERIOD_RESET   = 64'd49999,
   parameter int unsigned PRESCALE_W     = 16,
   parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        timeout_pulse
);

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
   localparam logic [2:0] ADDR_PRESCALE = 3'd6;
   localparam bit         HAS_HIGH      = (COUNT_W > 32);

   logic [COUNT_W-1:0]    counter;
   logic [COUNT_W-1:0]    period;
   logic [COUNT_W-1:0]    snapshot;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pcnt;
   logic                  to;
   logic                  run;
   logic                  ito;
   logic                  cont;
   logic                  reload_pend;

   logic        wr_c;
   logic        wr_status_c;
   logic        wr_control_c;
   logic        wr_period_c;
   logic        wr_snap_c;
   logic        wr_prescale_c;
   logic        start_c;
   logic        stop_c;
   logic        tick_c;
   logic        expire_c;
   logic [63:0] period_ext_c;
   logic [63:0] snap_ext_c;
   logic [63:0] period_nxt_c;
   logic [31:0] rd_mux_c;

   // Write decode; PERIOD_H only exists when the counter is wider than the bus
   assign wr_c          = chipselect & ~write_n;
   assign wr_status_c   = wr_c & (address == ADDR_STATUS);
   assign wr_control_c  = wr_c & (address == ADDR_CONTROL);
   assign wr_period_c   = wr_c & ((address == ADDR_PERIOD_L) |
                                  ((address == ADDR_PERIOD_H) & HAS_HIGH));
   assign wr_snap_c     = wr_c & ((address == ADDR_SNAP_L) | (address == ADDR_SNAP_H));
   assign wr_prescale_c = wr_c & (address == ADDR_PRESCALE);
   assign start_c       = wr_control_c & writedata[2];
   assign stop_c        = wr_control_c & writedata[3];

   assign tick_c   = run & (pcnt == '0);
   assign expire_c = tick_c & (counter == '0);

   assign period_ext_c = 64'(period);
   assign snap_ext_c   = 64'(snapshot);

   // Merge a half-word write into the zero-extended period image
   always_comb begin
      period_nxt_c = period_ext_c;
      if (wr_c && (address == ADDR_PERIOD_L)) begin
         period_nxt_c[31:0] = writedata;
      end
      if (wr_c && (address == ADDR_PERIOD_H) && HAS_HIGH) begin
         period_nxt_c[63:32] = writedata;
      end
   end

   always_comb begin
      rd_mux_c = '0;
      case (address)
         ADDR_STATUS:   rd_mux_c = {30'd0, run, to};
         ADDR_CONTROL:  rd_mux_c = {30'd0, cont, ito};
         ADDR_PERIOD_L: rd_mux_c = period_ext_c[31:0];
         ADDR_PERIOD_H: rd_mux_c = period_ext_c[63:32];
         ADDR_SNAP_L:   rd_mux_c = snap_ext_c[31:0];
         ADDR_SNAP_H:   rd_mux_c = snap_ext_c[63:32];
         ADDR_PRESCALE: rd_mux_c = 32'(prescale);
         default:       rd_mux_c = '0;
      endcase
   end

   // Host-visible configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period      <= COUNT_W'(PERIOD_RESET);
         prescale    <= PRESCALE_W'(PRESCALE_RESET);
         ito         <= 1'b0;
         cont        <= 1'b0;
         snapshot    <= '0;
         reload_pend <= 1'b0;
         readdata    <= '0;
      end else begin
         if (wr_period_c) begin
            period <= COUNT_W'(period_nxt_c);
         end
         if (wr_prescale_c) begin
            prescale <= writedata[PRESCALE_W-1:0];
         end
         if (wr_control_c) begin
            ito  <= writedata[0];
            cont <= writedata[1];
         end
         if (wr_snap_c) begin
            snapshot <= counter;
         end
         reload_pend <= wr_period_c;
         readdata    <= rd_mux_c;
      end
   end

   // Run flag and timeout status; a timeout beats a same-cycle status clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run           <= 1'b0;
         to            <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= expire_c;
         if (expire_c) begin
            to <= 1'b1;
         end else if (wr_status_c) begin
            to <= 1'b0;
         end
         if (start_c) begin
            run <= 1'b1;
         end else if (reload_pend || stop_c || (expire_c && !cont)) begin
            run <= 1'b0;
         end
      end
   end

   // Prescaler and down-counter; a pending period reload overrides counting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter <= COUNT_W'(PERIOD_RESET);
         pcnt    <= PRESCALE_W'(PRESCALE_RESET);
      end else begin
         if (start_c || reload_pend || tick_c) begin
            pcnt <= prescale;
         end else if (run && (pcnt != '0)) begin
            pcnt <= pcnt - PRESCALE_W'(1);
         end
         if (reload_pend) begin
            counter <= period;
         end else if (tick_c) begin
            if (counter == '0) begin
               counter <= period;
            end else begin
               counter <= counter - COUNT_W'(1);
            end
         end
      end
   end

   assign irq = to & ito;

endmodule

// File: tb/tb_nios2_ci_timer_gen2.sv
// Self-checking bench for nios2_ci_timer_gen2 (48-bit counter instance):
// table-driven register checks plus hand-written timing sequences.
module tb_nios2_ci_timer_gen2;

   localparam int unsigned COUNT_W = 48;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        timeout_pulse;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
      int          due;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[14];

   nios2_ci_timer_gen2 #(
      .COUNT_W        (COUNT_W),
      .PERIOD_RESET   (64'd49999),
      .PRESCALE_W     (16),
      .PRESCALE_RESET (32'd0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .chipselect    (chipselect),
      .write_n       (write_n),
      .writedata     (writedata),
      .readdata      (readdata),
      .irq           (irq),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard: read expectations are due one clock after the address is driven
   always @(negedge clk) begin
      sb_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         chk(e.name, readdata, e.exp);
      end
   end

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
      sb_t s;
      address = a;
      s.name  = n;
      s.exp   = e;
      s.due   = cyc + 1;
      sbq.push_back(s);
      @(negedge clk);
   endtask

   task automatic wait_pulse(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!timeout_pulse && n < limit);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n;
      logic [63:0] exp64;

      vecs[0]  = '{1'b0, 3'd2, 32'h0,        32'h0000C34F};
      vecs[1]  = '{1'b0, 3'd0, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 3'd6, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h0};
      vecs[4]  = '{1'b0, 3'd1, 32'h0,        32'h0};
      vecs[5]  = '{1'b0, 3'd7, 32'h0,        32'h0};
      vecs[6]  = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0000FFFF};
      vecs[7]  = '{1'b1, 3'd6, 32'h0,        32'h0};
      vecs[8]  = '{1'b1, 3'd3, 32'hFFFFFFFF, 32'h0000FFFF};
      vecs[9]  = '{1'b1, 3'd3, 32'h0,        32'h0};
      vecs[10] = '{1'b1, 3'd1, 32'h2,        32'h2};
      vecs[11] = '{1'b1, 3'd1, 32'h0,        32'h0};
      vecs[12] = '{1'b1, 3'd7, 32'hFFFFFFFF, 32'h0};
      vecs[13] = '{1'b0, 3'd0, 32'h0,        32'h0};

      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk("reset_irq", 32'(irq), 32'h0);
      chk("reset_pulse", 32'(timeout_pulse), 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
      end

      // One-shot, period 9, no prescale
      wr(3'd2, 32'd9);
      wr(3'd6, 32'd0);
      wr(3'd1, 32'h5);
      wait_pulse(100, n);
      chk("oneshot_latency", 32'(n), 32'd10);
      chk("oneshot_irq", 32'(irq), 32'h1);
      @(negedge clk);
      chk("oneshot_pulse_width", 32'(timeout_pulse), 32'h0);
      rd(3'd0, 32'h1, "oneshot_status");
      wr(3'd0, 32'h0);
      chk("oneshot_irq_clear", 32'(irq), 32'h0);
      rd(3'd0, 32'h0, "oneshot_status_clear");

      // Continuous, period 4, prescale 3
      wr(3'd2, 32'd4);
      wr(3'd6, 32'd3);
      wr(3'd1, 32'h7);
      address = 3'd0;
      wait_pulse(200, n);
      chk("cont_first", 32'(n), 32'd20);
      for (int k = 0; k < 2; k++) begin
         wait_pulse(200, n);
         chk($sformatf("cont_interval%0d", k), 32'(n), 32'd20);
      end
      chk("cont_status_running", readdata, 32'h3);
      wr(3'd1, 32'h8);
      rd(3'd0, 32'h1, "stop_status");
      repeat (3) @(negedge clk);
      wr(3'd4, 32'h0);
      rd(3'd4, 32'd4, "stop_counter_held");

      // 48-bit snapshot across the 32-bit borrow
      wr(3'd6, 32'd0);
      wr(3'd3, 32'd1);
      wr(3'd2, 32'd0);
      @(negedge clk);
      wr(3'd1, 32'h4);
      repeat (5) @(negedge clk);
      wr(3'd4, 32'h0);
      exp64 = 64'h1_0000_0000 - 64'd5;
      rd(3'd4, exp64[31:0], "snap_l");
      rd(3'd5, exp64[63:32], "snap_h");
      rd(3'd3, 32'h1, "period_h");
      wr(3'd1, 32'h8);

      // Status clear on the timeout edge; ITO=0 masks irq
      wr(3'd0, 32'h0);
      wr(3'd3, 32'd0);
      wr(3'd2, 32'd2);
      @(negedge clk);
      wr(3'd1, 32'h4);
      repeat (2) @(negedge clk);
      wr(3'd0, 32'h0);
      chk("simul_pulse", 32'(timeout_pulse), 32'h1);
      chk("simul_irq_masked", 32'(irq), 32'h0);
      rd(3'd0, 32'h1, "simul_status_set_wins");

      // Period 0: timeout on every tick
      wr(3'd0, 32'h0);
      wr(3'd2, 32'd0);
      @(negedge clk);
      wr(3'd1, 32'h6);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("period0_pulse%0d", k), 32'(timeout_pulse), 32'h1);
      end
      wr(3'd1, 32'h8);

      // Period write while running forces reload and stop
      wr(3'd0, 32'h0);
      wr(3'd2, 32'd50);
      @(negedge clk);
      wr(3'd1, 32'h6);
      repeat (10) @(negedge clk);
      wr(3'd2, 32'd100);
      @(negedge clk);
      rd(3'd0, 32'h0, "pwrite_stopped");
      wr(3'd4, 32'h0);
      rd(3'd4, 32'd100, "pwrite_counter");
      wr(3'd1, 32'h4);
      repeat (7) @(negedge clk);
      wr(3'd4, 32'h0);
      rd(3'd4, 32'd93, "pwrite_restart");

      // Mid-run reset
      wr(3'd1, 32'h7);
      address = 3'd2;
      wait_pulse(300, n);
      chk("prereset_timeout_seen", 32'(n < 300), 32'h1);
      chk("prereset_pulse", 32'(timeout_pulse), 32'h1);
      chk("prereset_irq", 32'(irq), 32'h1);
      chk("prereset_readdata", readdata, 32'd100);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_async_readdata", readdata, 32'h0);
      chk("reset_async_irq", 32'(irq), 32'h0);
      chk("reset_async_pulse", 32'(timeout_pulse), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rd(3'd2, 32'h0000C34F, "postreset_period");
      rd(3'd0, 32'h0, "postreset_status");
      rd(3'd1, 32'h0, "postreset_control");

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nios2_ci_timer_gen2.md
Name: nios2_ci_timer_gen2

Overview:
Parametrised successor to the team's 16-bit Avalon-MM interval timer, for Nios II CI systems. Adds configurable counter width up to 64 bits, a 32-bit data bus, a programmable clock prescaler and a one-cycle timeout strobe output. Sits on the Avalon-MM slave fabric and drives a CPU IRQ line. Timeout period is (period+1)*(prescale+1) clocks.

Parameters:
COUNT_W, 32, counter/period/snapshot width; legal 1..64.
PERIOD_RESET, 49999, reset value of the period register and of the counter.
PRESCALE_W, 16, prescale register width; legal 1..32.
PRESCALE_RESET, 0, reset value of the prescale register; divide ratio = value+1.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
address  in  3  Avalon word address
chipselect  in  1  slave select
write_n  in  1  active-low write
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  level interrupt = TO & ITO
timeout_pulse  out  1  one-clock strobe per timeout event

Behaviour:
- Write strobe wr = chipselect & ~write_n. Zero wait states; one write per cycle.
- Register map:
  - 0 STATUS: bit0 TO, bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. START and STOP are write-one strobes and read back 0. Bits [1:0] are stored.
  - 2 PERIOD_L: period[31:0].
  - 3 PERIOD_H: period[COUNT_W-1:32]. When COUNT_W<=32, reads 0 and writes are ignored.
  - 4 SNAP_L / 5 SNAP_H: a write captures the counter; a read returns the captured value, split the same way as PERIOD.
  - 6 PRESCALE: bits [PRESCALE_W-1:0].
  - 7: reads 0.
  - Bits above the implemented width read 0.
- Read: readdata is registered from address every clock, independent of chipselect. Latency is 1 cycle.
- Reset values:
  - counter = period = PERIOD_RESET; prescale reg = prescale cnt = PRESCALE_RESET.
  - control, TO, RUN, snapshot, readdata, irq and timeout_pulse = 0.
  - Reset is honoured mid-operation; no state survives it.
- Prescaler:
  - tick = RUN & (pcnt==0).
  - On tick, pcnt <= prescale reg. While RUN and pcnt!=0, pcnt decrements.
  - START and any reload reset pcnt to the prescale reg value.
  - A PRESCALE write takes effect at the next pcnt reload.
- Counter, on tick:
  - If counter==0: counter <= period; TO <= 1; timeout_pulse = 1 for one cycle (registered); if CONT==0, RUN <= 0.
  - Otherwise: counter <= counter-1, modulo 2^COUNT_W.
- Start/stop:
  - START sets RUN at the write edge. It does not reload the counter; counting resumes from the current value.
  - STOP clears RUN.
  - START and STOP in the same write: START wins.
- Period write:
  - At the write edge, period is updated.
  - In the next cycle the counter loads the full new period, RUN clears and pcnt reloads.
  - The counter is never reloaded with a half-written period.
- Snapshot: captures the counter value present before the write edge's update.
- Status clear in the same cycle as a timeout event: set wins, so TO stays 1. No event is lost.
- Period 0: a timeout occurs on every tick.
- Period write in the same cycle as a timeout tick: the timeout is still recorded, then the forced reload and stop apply.
- irq is combinational from TO and ITO. ITO=0 masks irq but TO still sets.

Test Plan:
- Reset, then read addr 2, 0 and 6 -> readdata 0x0000C34F, 0x0, 0x0 (one cycle after address); irq=0; timeout_pulse=0.
- One-shot: PERIOD_L=9, PRESCALE=0, then CONTROL=0x5 -> after exactly 10 clocks from the START edge: TO=1, irq=1, RUN=0, timeout_pulse high for 1 clock. Write STATUS -> irq=0 on the next cycle.
- Continuous: PERIOD_L=4, PRESCALE=3, CONTROL=0x7 -> timeout_pulse every 20 clocks for 3 consecutive events; RUN stays 1. CONTROL=0x8 -> RUN=0 and the counter holds.
- Snapshot with COUNT_W=48: PERIOD_H=0x1, PERIOD_L=0x0, start, write addr 4 -> SNAP_L/SNAP_H match the model counter at the write edge; reading addr 3 returns 0x00000001.
- Simultaneous events: a STATUS write on the timeout tick cycle -> TO=1 afterwards. A PERIOD_L=100 write while running -> the next cycle has RUN=0 and counter=100, and a later START counts from 100.
- Mid-run reset: assert reset_n=0 during a continuous run -> all outputs 0 immediately. After release, PERIOD reads 49999 and RUN=0.
